// File: rtl/sram_responder.sv
// Target end of the CPU byte-bus handshake: runs a wait-stated access to an
// external asynchronous SRAM and returns a one-cycle acknowledge.
module sram_responder #(
    parameter int WAIT_STATES = 2,
    parameter int ADDR_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_sel,
    input  logic [15:0]       i_addr,
    input  logic [7:0]        i_dat,
    input  logic              i_we,
    output logic [7:0]        o_dat,
    output logic              o_ack,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [7:0]        o_sram_dat,
    output logic              o_sram_dat_oe,
    input  logic [7:0]        i_sram_dat,
    output logic              o_sram_ce_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_we_n
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        HOLD,
        ACK
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t     state;
    logic [3:0] count;
    logic       is_write;

    // Upper address bits are dropped when ADDR_W < 16.
    logic unused_addr;
    assign unused_addr = ^i_addr;

    // Every output is a register; strobes are set up on the edge that enters
    // each state so they are clean for the whole cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= IDLE;
            count         <= '0;
            is_write      <= 1'b0;
            o_dat         <= 8'h00;
            o_ack         <= 1'b0;
            o_busy        <= 1'b0;
            o_sram_addr   <= '0;
            o_sram_dat    <= 8'h00;
            o_sram_dat_oe <= 1'b0;
            o_sram_ce_n   <= 1'b1;
            o_sram_oe_n   <= 1'b1;
            o_sram_we_n   <= 1'b1;
        end else begin
            o_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_sel) begin
                        o_sram_addr   <= i_addr[ADDR_W-1:0];
                        o_sram_dat    <= i_dat;
                        is_write      <= i_we;
                        count         <= WAIT_INIT;
                        state         <= ACCESS;
                        o_busy        <= 1'b1;
                        o_sram_ce_n   <= 1'b0;
                        o_sram_oe_n   <= i_we;
                        o_sram_we_n   <= ~i_we;
                        o_sram_dat_oe <= i_we;
                    end
                end
                ACCESS: begin
                    if (count == 4'd0) begin
                        if (is_write) begin
                            // Release we_n but keep ce_n and data driven for hold time.
                            state       <= HOLD;
                            o_sram_we_n <= 1'b1;
                        end else begin
                            o_dat       <= i_sram_dat;
                            o_ack       <= 1'b1;
                            state       <= ACK;
                            o_sram_ce_n <= 1'b1;
                            o_sram_oe_n <= 1'b1;
                        end
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                HOLD: begin
                    state         <= ACK;
                    o_ack         <= 1'b1;
                    o_sram_ce_n   <= 1'b1;
                    o_sram_dat_oe <= 1'b0;
                end
                ACK: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    o_busy        <= 1'b0;
                    o_sram_ce_n   <= 1'b1;
                    o_sram_oe_n   <= 1'b1;
                    o_sram_we_n   <= 1'b1;
                    o_sram_dat_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: four instances with different
// wait states / address widths, each backed by a simple SRAM model.
module tb_sram_responder;

    logic        clk;
    logic        reset;
    logic        sel;
    logic [15:0] addr;
    logic [7:0]  wdat;
    logic        we;
    int          cur;

    logic        sel_k   [4];
    logic [7:0]  dat_k   [4];
    logic        ack_k   [4];
    logic        busy_k  [4];
    logic [15:0] saddr_k [4];
    logic [7:0]  sdat_k  [4];
    logic        doe_k   [4];
    logic [7:0]  srd_k   [4];
    logic        ce_k    [4];
    logic        oe_k    [4];
    logic        wen_k   [4];
    logic [11:0] saddr_d;

    logic [7:0]  mem [4][65536];

    logic        v_ack, v_busy, v_ce, v_oe, v_we, v_doe;
    logic [7:0]  v_dat, v_wdat;
    logic [15:0] v_addr;

    int checks;
    int failures;

    localparam int WS_OF [4] = '{2, 0, 1, 2};

    typedef struct {
        int          dut;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdat;
        logic [15:0] exp_addr;
        logic [7:0]  exp_dat;
    } vec_t;

    vec_t vecs [12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            sel_k[k] = sel && (cur == k);
            srd_k[k] = (!ce_k[k] && !oe_k[k]) ? mem[k][saddr_k[k]] : 8'hEE;
        end
    end

    assign saddr_k[3] = {4'h0, saddr_d};

    // SRAM model: writes land on any clock edge where ce_n and we_n are low.
    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++)
                for (int a = 0; a < 65536; a++)
                    mem[k][a] <= 8'h00;
            mem[0][16'h1234] <= 8'hA5;
            mem[1][16'h0005] <= 8'h9D;
            mem[2][16'h0040] <= 8'hC3;
            mem[3][16'h0123] <= 8'h6E;
        end else begin
            for (int k = 0; k < 4; k++)
                if (!ce_k[k] && !wen_k[k])
                    mem[k][saddr_k[k]] <= sdat_k[k];
        end
    end

    always_comb begin
        v_ack  = ack_k[cur];
        v_busy = busy_k[cur];
        v_ce   = ce_k[cur];
        v_oe   = oe_k[cur];
        v_we   = wen_k[cur];
        v_doe  = doe_k[cur];
        v_dat  = dat_k[cur];
        v_wdat = sdat_k[cur];
        v_addr = saddr_k[cur];
    end

    sram_responder #(.WAIT_STATES(2), .ADDR_W(16)) dut_a (
        .i_clk(clk), .i_reset(reset), .i_sel(sel_k[0]), .i_addr(addr), .i_dat(wdat), .i_we(we),
        .o_dat(dat_k[0]), .o_ack(ack_k[0]), .o_busy(busy_k[0]), .o_sram_addr(saddr_k[0]),
        .o_sram_dat(sdat_k[0]), .o_sram_dat_oe(doe_k[0]), .i_sram_dat(srd_k[0]),
        .o_sram_ce_n(ce_k[0]), .o_sram_oe_n(oe_k[0]), .o_sram_we_n(wen_k[0]));

    sram_responder #(.WAIT_STATES(0), .ADDR_W(16)) dut_b (
        .i_clk(clk), .i_reset(reset), .i_sel(sel_k[1]), .i_addr(addr), .i_dat(wdat), .i_we(we),
        .o_dat(dat_k[1]), .o_ack(ack_k[1]), .o_busy(busy_k[1]), .o_sram_addr(saddr_k[1]),
        .o_sram_dat(sdat_k[1]), .o_sram_dat_oe(doe_k[1]), .i_sram_dat(srd_k[1]),
        .o_sram_ce_n(ce_k[1]), .o_sram_oe_n(oe_k[1]), .o_sram_we_n(wen_k[1]));

    sram_responder #(.WAIT_STATES(1), .ADDR_W(16)) dut_c (
        .i_clk(clk), .i_reset(reset), .i_sel(sel_k[2]), .i_addr(addr), .i_dat(wdat), .i_we(we),
        .o_dat(dat_k[2]), .o_ack(ack_k[2]), .o_busy(busy_k[2]), .o_sram_addr(saddr_k[2]),
        .o_sram_dat(sdat_k[2]), .o_sram_dat_oe(doe_k[2]), .i_sram_dat(srd_k[2]),
        .o_sram_ce_n(ce_k[2]), .o_sram_oe_n(oe_k[2]), .o_sram_we_n(wen_k[2]));

    sram_responder #(.WAIT_STATES(2), .ADDR_W(12)) dut_d (
        .i_clk(clk), .i_reset(reset), .i_sel(sel_k[3]), .i_addr(addr), .i_dat(wdat), .i_we(we),
        .o_dat(dat_k[3]), .o_ack(ack_k[3]), .o_busy(busy_k[3]), .o_sram_addr(saddr_d),
        .o_sram_dat(sdat_k[3]), .o_sram_dat_oe(doe_k[3]), .i_sram_dat(srd_k[3]),
        .o_sram_ce_n(ce_k[3]), .o_sram_oe_n(oe_k[3]), .o_sram_we_n(wen_k[3]));

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One transaction, request held for cycle 0 only; every cycle through a
    // short idle tail is checked against the expected strobe timeline.
    task automatic applyStimulus(input vec_t v);
        int ws;
        int ackc;
        bit acc;
        bit hold;
        logic [5:0] exp_bundle;
        ws   = WS_OF[v.dut];
        ackc = v.we ? ws + 3 : ws + 2;
        cur  = v.dut;
        @(posedge clk); #1;
        sel = 1'b1; we = v.we; addr = v.addr; wdat = v.wdat;
        for (int c = 0; c <= ackc + 3; c++) begin
            @(negedge clk);
            acc  = (c >= 1) && (c <= ws + 1);
            hold = v.we && (c == ws + 2);
            exp_bundle = {(c == ackc), (c >= 1 && c <= ackc), !(acc || hold),
                          !(acc && !v.we), !(acc && v.we), v.we && (acc || hold)};
            checkOutput($sformatf("d%0d a%04h c%0d ack/busy/ce/oe/we/doe", v.dut, v.addr, c),
                        32'({v_ack, v_busy, v_ce, v_oe, v_we, v_doe}), 32'(exp_bundle));
            if (acc)
                checkOutput($sformatf("d%0d a%04h c%0d sram_addr", v.dut, v.addr, c),
                            32'(v_addr), 32'(v.exp_addr));
            if (v.we && (acc || hold))
                checkOutput($sformatf("d%0d a%04h c%0d sram_dat", v.dut, v.addr, c),
                            32'(v_wdat), 32'(v.wdat));
            if (c == ackc)
                checkOutput($sformatf("d%0d a%04h o_dat", v.dut, v.addr),
                            32'(v_dat), 32'(v.exp_dat));
            @(posedge clk); #1;
            sel = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit seen_ack;
        checks = 0; failures = 0;
        cur = 0; sel = 1'b0; we = 1'b0; addr = 16'h0; wdat = 8'h0;

        vecs[0]  = '{0, 1'b0, 16'h1234, 8'h00, 16'h1234, 8'hA5};
        vecs[1]  = '{0, 1'b1, 16'h00FF, 8'h3C, 16'h00FF, 8'hA5};
        vecs[2]  = '{0, 1'b0, 16'h00FF, 8'h00, 16'h00FF, 8'h3C};
        vecs[3]  = '{0, 1'b1, 16'h8001, 8'h5A, 16'h8001, 8'h3C};
        vecs[4]  = '{0, 1'b0, 16'h0000, 8'h00, 16'h0000, 8'h00};
        vecs[5]  = '{0, 1'b0, 16'h8001, 8'h00, 16'h8001, 8'h5A};
        vecs[6]  = '{2, 1'b0, 16'h0040, 8'h00, 16'h0040, 8'hC3};
        vecs[7]  = '{2, 1'b1, 16'h0041, 8'h11, 16'h0041, 8'hC3};
        vecs[8]  = '{3, 1'b0, 16'hF123, 8'h00, 16'h0123, 8'h6E};
        vecs[9]  = '{3, 1'b1, 16'hF0FE, 8'h42, 16'h00FE, 8'h6E};
        vecs[10] = '{3, 1'b0, 16'h00FE, 8'h00, 16'h00FE, 8'h42};
        vecs[11] = '{1, 1'b0, 16'h0005, 8'h00, 16'h0005, 8'h9D};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            cur = k;
            @(negedge clk);
            checkOutput($sformatf("reset d%0d ack/busy/ce/oe/we/doe", k),
                        32'({v_ack, v_busy, v_ce, v_oe, v_we, v_doe}), 32'(6'b00_1110));
            checkOutput($sformatf("reset d%0d o_dat/addr/sdat", k),
                        {v_dat, v_addr, v_wdat}, 32'h0);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 12; i++)
            applyStimulus(vecs[i]);

        // Back-to-back write then read on the zero-wait-state instance.
        cur = 1;
        @(posedge clk); #1;
        sel = 1'b1; we = 1'b1; addr = 16'h0010; wdat = 8'h77;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            checkOutput($sformatf("b2b c%0d ack", c), 32'(v_ack), 32'((c == 3) || (c == 6)));
            checkOutput($sformatf("b2b c%0d busy", c), 32'(v_busy),
                        32'((c >= 1 && c <= 3) || (c >= 5 && c <= 6)));
            if (c == 5) begin
                checkOutput("b2b c5 oe_n", 32'(v_oe), 32'(1'b0));
                checkOutput("b2b c5 sram_addr", 32'(v_addr), 32'h0010);
            end
            if (c == 6)
                checkOutput("b2b read o_dat", 32'(v_dat), 32'h77);
            @(posedge clk); #1;
            if (c + 1 == 4) begin
                sel = 1'b1; we = 1'b0;
            end else if (c + 1 > 4) begin
                sel = 1'b0;
            end
        end

        // Reset arriving in cycle 2 of a write.
        cur = 0;
        @(posedge clk); #1;
        sel = 1'b1; we = 1'b1; addr = 16'h0200; wdat = 8'h99;
        @(posedge clk); #1;
        sel = 1'b0;
        @(negedge clk);
        checkOutput("rstmid c1 we_n", 32'(v_we), 32'(1'b0));
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rstmid c2 we_n", 32'(v_we), 32'(1'b0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rstmid c3 ack/busy/ce/oe/we/doe",
                    32'({v_ack, v_busy, v_ce, v_oe, v_we, v_doe}), 32'(6'b00_1110));
        checkOutput("rstmid c3 o_dat", 32'(v_dat), 32'h00);
        seen_ack = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (v_ack) seen_ack = 1'b1;
        end
        checkOutput("rstmid no ack", 32'(seen_ack), 32'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
